// File: rtl/writeback_queue.sv
// writeback_queue: in-order merge of ALU and load results into the register file write port, with forwarding lookups.
module writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_data,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic          mem_ready,
    output logic          stall,
    output logic          overflow,
    output logic          enc,
    output logic [AW-1:0] addrc,
    output logic [DW-1:0] datac,
    input  logic [AW-1:0] qa_addr,
    output logic          qa_hit,
    output logic [DW-1:0] qa_data,
    input  logic [AW-1:0] qb_addr,
    output logic          qb_hit,
    output logic [DW-1:0] qb_data
);
    localparam int PW = $clog2(DEPTH);
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head, tail, mem_slot, idx;
    logic [PW:0]   count, free;
    logic          alu_st, mem_st, deq;
    assign free      = (PW+1)'(DEPTH) - count;
    assign stall     = free == '0;
    assign mem_ready = free >= (PW+1)'(2);
    // r0 results complete the handshake but are never stored
    assign alu_st    = alu_valid && !stall && |alu_addr;
    assign mem_st    = mem_valid && mem_ready && |mem_addr;
    assign deq       = count != '0;
    assign mem_slot  = tail + PW'(alu_st);
    always_ff @(posedge clock) begin
        if (alu_st) begin
            addr_q[tail] <= alu_addr;
            data_q[tail] <= alu_data;
        end
        if (mem_st) begin
            addr_q[mem_slot] <= mem_addr;
            data_q[mem_slot] <= mem_data;
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
            enc      <= 1'b0;
            addrc    <= '0;
            datac    <= '0;
        end else begin
            head     <= head + PW'(deq);
            tail     <= tail + PW'(alu_st) + PW'(mem_st);
            count    <= count + (PW+1)'(alu_st) + (PW+1)'(mem_st) - (PW+1)'(deq);
            overflow <= overflow | (alu_valid && stall);
            enc      <= deq;
            if (deq) begin
                addrc <= addr_q[head];
                datac <= data_q[head];
            end
        end
    end
    // scan oldest to youngest so later matches override earlier ones
    always_comb begin
        qa_hit  = 1'b0;
        qa_data = '0;
        qb_hit  = 1'b0;
        qb_data = '0;
        idx     = head;
        if (enc && addrc == qa_addr) begin
            qa_hit  = 1'b1;
            qa_data = datac;
        end
        if (enc && addrc == qb_addr) begin
            qb_hit  = 1'b1;
            qb_data = datac;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((PW+1)'(i) < count && addr_q[idx] == qa_addr) begin
                qa_hit  = 1'b1;
                qa_data = data_q[idx];
            end
            if ((PW+1)'(i) < count && addr_q[idx] == qb_addr) begin
                qb_hit  = 1'b1;
                qb_data = data_q[idx];
            end
        end
        if (qa_addr == '0) begin
            qa_hit  = 1'b0;
            qa_data = '0;
        end
        if (qb_addr == '0) begin
            qb_hit  = 1'b0;
            qb_data = '0;
        end
    end
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: randomized scoreboard bench driving a DEPTH=4 and a DEPTH=2 queue with shared stimulus.
module tb_writeback_queue;
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        alu_valid = 1'b0, mem_valid = 1'b0;
    logic [4:0]  alu_addr = '0, mem_addr = '0, qa_addr = '0, qb_addr = '0;
    logic [31:0] alu_data = '0, mem_data = '0;
    logic        stall [2], mem_ready [2], overflow [2], enc [2], qa_hit [2], qb_hit [2];
    logic [4:0]  addrc [2];
    logic [31:0] datac [2], qa_data [2], qb_data [2];
    ent_t        mq [2][$];
    ent_t        sb [2][$];
    ent_t        m_out [2];
    logic        m_ov [2], m_of [2];
    int          n_tests = 0, n_fail = 0;

    always #5 clock = ~clock;

    writeback_queue #(.DEPTH(4), .AW(5), .DW(32)) u_d4 (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_ready(mem_ready[0]), .stall(stall[0]), .overflow(overflow[0]),
        .enc(enc[0]), .addrc(addrc[0]), .datac(datac[0]),
        .qa_addr(qa_addr), .qa_hit(qa_hit[0]), .qa_data(qa_data[0]),
        .qb_addr(qb_addr), .qb_hit(qb_hit[0]), .qb_data(qb_data[0]));

    writeback_queue #(.DEPTH(2), .AW(5), .DW(32)) u_d2 (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_ready(mem_ready[1]), .stall(stall[1]), .overflow(overflow[1]),
        .enc(enc[1]), .addrc(addrc[1]), .datac(datac[1]),
        .qa_addr(qa_addr), .qa_hit(qa_hit[1]), .qa_data(qa_data[1]),
        .qb_addr(qb_addr), .qb_hit(qb_hit[1]), .qb_data(qb_data[1]));

    function automatic int dep(input int k);
        return (k == 0) ? 4 : 2;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s depth%0d: got %h expected %h at %0t", name, dep(k), act, exp, $time);
        end
    endtask

    // youngest in-flight value wins; the write port is the oldest source
    task automatic fwd_exp(input int k, input logic [4:0] q, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        if (q != 0) begin
            for (int i = mq[k].size() - 1; i >= 0; i--)
                if (!h && mq[k][i].a == q) begin
                    h = 1'b1;
                    d = mq[k][i].d;
                end
            if (!h && m_ov[k] && m_out[k].a == q) begin
                h = 1'b1;
                d = m_out[k].d;
            end
        end
    endtask

    task automatic flush_model();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            sb[k].delete();
            m_ov[k]  = 1'b0;
            m_of[k]  = 1'b0;
            m_out[k] = '0;
        end
    endtask

    task automatic cyc(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic [4:0] qa, input logic [4:0] qb);
        logic h;
        logic [31:0] d;
        logic st, mr;
        logic aacc [2], macc [2];
        @(negedge clock);
        alu_valid = av; alu_addr = aa; alu_data = ad;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        qa_addr = qa; qb_addr = qb;
        #1;
        for (int k = 0; k < 2; k++) begin
            st = mq[k].size() == dep(k);
            mr = dep(k) - mq[k].size() >= 2;
            chk("stall", k, 32'(stall[k]), 32'(st));
            chk("mem_ready", k, 32'(mem_ready[k]), 32'(mr));
            chk("enc", k, 32'(enc[k]), 32'(m_ov[k]));
            chk("overflow", k, 32'(overflow[k]), 32'(m_of[k]));
            fwd_exp(k, qa, h, d);
            chk("qa_hit", k, 32'(qa_hit[k]), 32'(h));
            chk("qa_data", k, qa_data[k], d);
            fwd_exp(k, qb, h, d);
            chk("qb_hit", k, 32'(qb_hit[k]), 32'(h));
            chk("qb_data", k, qb_data[k], d);
            aacc[k] = av && !st;
            macc[k] = mv && mr;
            if (av && st) m_of[k] = 1'b1;
        end
        @(posedge clock);
        for (int k = 0; k < 2; k++) begin
            m_ov[k] = mq[k].size() > 0;
            if (m_ov[k]) m_out[k] = mq[k].pop_front();
            if (aacc[k] && aa != 0) begin
                mq[k].push_back('{aa, ad});
                sb[k].push_back('{aa, ad});
            end
            if (macc[k] && ma != 0) begin
                mq[k].push_back('{ma, md});
                sb[k].push_back('{ma, md});
            end
        end
    endtask

    task automatic idle(input logic [4:0] qa);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, qa, 5'd0);
    endtask

    // called right after an active edge, so the pulse lands mid-cycle
    task automatic mid_reset(input logic [4:0] qa);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        qa_addr   = qa;
        #2 reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_enc", k, 32'(enc[k]), 32'd0);
            chk("rst_qa_hit", k, 32'(qa_hit[k]), 32'd0);
            chk("rst_stall", k, 32'(stall[k]), 32'd0);
            chk("rst_mem_ready", k, 32'(mem_ready[k]), 32'd1);
            chk("rst_overflow", k, 32'(overflow[k]), 32'd0);
        end
        flush_model();
        #1 reset = 1'b1;
    endtask

    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (enc[k]) begin
                if (sb[k].size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL retire depth%0d: got unexpected write r%0d=%h expected none", dep(k), addrc[k], datac[k]);
                end else begin
                    ent_t e;
                    e = sb[k].pop_front();
                    chk("retire_addr", k, 32'(addrc[k]), 32'(e.a));
                    chk("retire_data", k, datac[k], e.d);
                end
            end
        end
    end

    initial begin
        flush_model();
        #2;
        for (int k = 0; k < 2; k++) begin
            chk("reset_enc", k, 32'(enc[k]), 32'd0);
            chk("reset_addrc", k, 32'(addrc[k]), 32'd0);
            chk("reset_datac", k, datac[k], 32'd0);
            chk("reset_overflow", k, 32'(overflow[k]), 32'd0);
        end
        #10 reset = 1'b1;
        cyc(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
        idle(5'd3);
        idle(5'd3);
        cyc(1'b1, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB, 5'd5, 5'd0);
        idle(5'd5);
        idle(5'd5);
        idle(5'd5);
        cyc(1'b1, 5'd0, 32'h77, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        idle(5'd0);
        idle(5'd0);
        for (int i = 0; i < 6; i++)
            cyc(1'b1, 5'(i + 8), 32'(i) + 32'h100, 1'b1, 5'(i + 16), 32'(i) + 32'h200, 5'(i + 8), 5'(i + 15));
        mid_reset(5'd9);
        cyc(1'b1, 5'd1, 32'h301, 1'b1, 5'd2, 32'h302, 5'd1, 5'd2);
        cyc(1'b1, 5'd3, 32'h303, 1'b1, 5'd4, 32'h304, 5'd3, 5'd4);
        mid_reset(5'd4);
        for (int i = 0; i < 300; i++)
            cyc($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        for (int i = 0; i < 8; i++) idle(5'($urandom_range(0, 7)));
        for (int k = 0; k < 2; k++) chk("drained", k, 32'(sb[k].size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
